mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a request/ack data-memory port and a MEM/WB result register.
// Memory accesses stall the upstream stages. A misaligned address or an ack timeout raises a one-cycle error pulse.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] StoreData_i,
  input  logic [4:0]  WriteReg_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  WriteReg_o,
  output logic [31:0] WriteData_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  writereg_q, writereg_d;
  logic [31:0] writedata_q, writedata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic        abort_q, abort_d;

  logic memop;
  logic aligned;

  assign memop   = MemRead_i | MemWrite_i;
  assign aligned = (ALUResult_i[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    regwrite_d  = regwrite_q;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
    load_d      = load_q;
    abort_d     = abort_q;
    stall_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop && aligned) begin
          stall_o    = 1'b1;
          state_d    = S_ACCESS;
          req_d      = 1'b1;
          we_d       = MemWrite_i;
          addr_d     = ALUResult_i;
          wdata_d    = StoreData_i;
          cnt_d      = '0;
          abort_d    = 1'b0;
          regwrite_d = 1'b0;
        end else if (memop) begin
          misalign_d = 1'b1;
          regwrite_d = 1'b0;
        end else begin
          regwrite_d  = RegWrite_i;
          writereg_d  = WriteReg_i;
          writedata_d = ALUResult_i;
        end
      end

      S_ACCESS: begin
        stall_o    = 1'b1;
        regwrite_d = 1'b0;
        // An ack on the final allowed cycle still counts as a normal completion.
        if (dmem_ack_i) begin
          load_d  = dmem_rdata_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (MemWrite_i || abort_q) begin
          regwrite_d = 1'b0;
        end else begin
          regwrite_d  = RegWrite_i;
          writereg_d  = WriteReg_i;
          writedata_d = MemToReg_i ? load_q : ALUResult_i;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      load_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      abort_q     <= abort_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign RegWrite_o   = regwrite_q;
  assign WriteReg_o   = writereg_q;
  assign WriteData_o  = writedata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule
